// File: rtl/memory_arbiter.sv
// Arbitrates one external memory port between instruction fetch and the data path (ld/st/cx).
// cx is an atomic read-compare-write with fetch locked out; data priority is bounded by MAX_DATA_BURST.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  input  logic                     fetch_cancel,
  output logic                     fetch_ready,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  input  logic                     data_request,
  input  logic                     data_read,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]    data_write_data,
  input  logic [DATA_WIDTH-1:0]    data_compare,
  output logic                     data_ready,
  output logic [DATA_WIDTH-1:0]    data_read_data,
  output logic                     cx_success,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  input  logic                     mem_ready
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DATA_READ, DATA_WRITE, CX_READ, CX_WRITE, ERROR
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_grant_fetch;
  logic                     w_grant_data;
  logic                     w_fetch_eligible;
  logic                     w_burst_full;
  logic                     w_turnaround;
  logic                     w_cx_match;

  logic [BW-1:0]            r_burst;
  logic                     r_fetch_dropped;
  logic [DATA_WIDTH-1:0]    r_old;
  logic                     r_fetch_ready;
  logic [DATA_WIDTH-1:0]    r_fetch_data;
  logic                     r_data_ready;
  logic [DATA_WIDTH-1:0]    r_data_read_data;
  logic                     r_cx_success;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic [DATA_WIDTH-1:0]    r_mem_write_data;

  assign fetch_ready    = r_fetch_ready;
  assign fetch_data     = r_fetch_data;
  assign data_ready     = r_data_ready;
  assign data_read_data = r_data_read_data;
  assign cx_success     = r_cx_success;
  assign mem_address    = r_mem_address;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_write_data = r_mem_write_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A completion cycle is a turnaround with no grant: the finishing requester is still
  // holding its request, and a back-to-back data stream keeps its place for the burst limit.
  always_comb begin
    w_state_next     = r_state;
    w_grant_fetch    = 1'b0;
    w_grant_data     = 1'b0;
    w_fetch_eligible = fetch_request && !fetch_cancel && !r_fetch_ready;
    w_burst_full     = (r_burst == BW'(MAX_DATA_BURST));
    w_turnaround     = r_fetch_ready || r_data_ready;
    w_cx_match       = (mem_read_data == data_compare);
    case (r_state)
      IDLE: begin
        if (!w_turnaround) begin
          if (w_fetch_eligible && (!data_request || w_burst_full)) begin
            w_grant_fetch = 1'b1;
            w_state_next  = FETCH;
          end else if (data_request) begin
            w_grant_data = 1'b1;
            if (data_read && data_write) w_state_next = CX_READ;
            else if (data_read)          w_state_next = DATA_READ;
            else if (data_write)         w_state_next = DATA_WRITE;
            else                         w_state_next = ERROR;
          end
        end
      end
      FETCH, DATA_READ, DATA_WRITE, CX_WRITE: begin
        if (mem_ready) w_state_next = IDLE;
      end
      CX_READ: begin
        if (mem_ready) w_state_next = w_cx_match ? CX_WRITE : IDLE;
      end
      ERROR:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_burst          <= '0;
      r_fetch_dropped  <= 1'b0;
      r_old            <= '0;
      r_fetch_ready    <= 1'b0;
      r_fetch_data     <= '0;
      r_data_ready     <= 1'b0;
      r_data_read_data <= '0;
      r_cx_success     <= 1'b0;
      r_mem_address    <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_write_data <= '0;
    end else begin
      r_fetch_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_cx_success  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_fetch) begin
            r_mem_address   <= fetch_address;
            r_mem_read      <= 1'b1;
            r_mem_write     <= 1'b0;
            r_fetch_dropped <= 1'b0;
            r_burst         <= '0;
          end else if (w_grant_data) begin
            r_mem_address    <= data_address;
            r_mem_read       <= data_read;
            r_mem_write      <= data_write && !data_read;
            r_mem_write_data <= data_write_data;
            if (!data_read && !data_write) begin
              r_data_ready     <= 1'b1;
              r_data_read_data <= '0;
            end
            if (!(fetch_request && !fetch_cancel)) r_burst <= '0;
            else if (!w_burst_full)                r_burst <= r_burst + BW'(1);
          end
        end
        FETCH: begin
          if (fetch_cancel) r_fetch_dropped <= 1'b1;
          if (mem_ready) begin
            r_mem_read <= 1'b0;
            if (!r_fetch_dropped && !fetch_cancel) begin
              r_fetch_ready <= 1'b1;
              r_fetch_data  <= mem_read_data;
            end
          end
        end
        DATA_READ: begin
          if (mem_ready) begin
            r_mem_read       <= 1'b0;
            r_data_ready     <= 1'b1;
            r_data_read_data <= mem_read_data;
          end
        end
        DATA_WRITE: begin
          if (mem_ready) begin
            r_mem_write      <= 1'b0;
            r_data_ready     <= 1'b1;
            r_data_read_data <= '0;
          end
        end
        CX_READ: begin
          if (mem_ready) begin
            r_mem_read <= 1'b0;
            r_old      <= mem_read_data;
            if (w_cx_match) begin
              r_mem_write      <= 1'b1;
              r_mem_write_data <= data_write_data;
            end else begin
              r_data_ready     <= 1'b1;
              r_data_read_data <= mem_read_data;
            end
          end
        end
        CX_WRITE: begin
          if (mem_ready) begin
            r_mem_write      <= 1'b0;
            r_data_ready     <= 1'b1;
            r_cx_success     <= 1'b1;
            r_data_read_data <= r_old;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small wait-state memory model.
module tb_memory_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_request, fetch_cancel, fetch_ready;
  logic [31:0] fetch_address, fetch_data;
  logic        data_request, data_read, data_write, data_ready, cx_success;
  logic [31:0] data_address, data_write_data, data_compare, data_read_data;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, mem_ready;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:255];
  int wcnt;
  int wait_states;

  logic        got, fdone, fgrant, prev_rd, leak, wseen, dr, cx_s, fr, fseen, drs;
  int          dgrants, dgrants_before, rdcyc;
  logic [31:0] rdd, fd;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address), .fetch_cancel(fetch_cancel),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .data_request(data_request), .data_read(data_read), .data_write(data_write),
    .data_address(data_address), .data_write_data(data_write_data), .data_compare(data_compare),
    .data_ready(data_ready), .data_read_data(data_read_data), .cx_success(cx_success),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  assign mem_ready     = (mem_read || mem_write) && (wcnt >= wait_states);
  assign mem_read_data = mem_read ? mem[mem_address[9:2]] : 32'h0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[8] <= 32'd5;
      wcnt   <= 0;
    end else if (mem_read || mem_write) begin
      if (mem_ready) begin
        wcnt <= 0;
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    fetch_request = 0; fetch_cancel = 0; fetch_address = 0;
    data_request = 0; data_read = 0; data_write = 0;
    data_address = 0; data_write_data = 0; data_compare = 0;
    wait_states = 0;
    tick(); tick();
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_cx_success", cx_success, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_read_data", data_read_data, 0);
    reset = 1'b0;

    // fetch only, zero wait states
    fetch_address = 32'h100; fetch_request = 1;
    tick();
    chk("f1_mem_read", mem_read, 1);
    chk("f1_mem_address", mem_address, 32'h100);
    chk("f1_mem_write", mem_write, 0);
    tick();
    chk("f1_fetch_ready", fetch_ready, 1);
    chk("f1_fetch_data", fetch_data, 32'hA000_0040);
    tick();
    chk("f1_no_regrant", mem_read, 0);
    chk("f1_ready_pulse", fetch_ready, 0);
    fetch_request = 0;
    tick();

    // fetch and ld together: data first, then fetch
    fetch_address = 32'h200; fetch_request = 1;
    data_address = 32'h40; data_read = 1; data_write = 0; data_request = 1;
    tick();
    chk("f2_data_first", mem_address, 32'h40);
    chk("f2_data_rd", mem_read, 1);
    tick();
    chk("f2_data_ready", data_ready, 1);
    chk("f2_ld_value", data_read_data, 32'hA000_0010);
    data_request = 0; data_read = 0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (mem_read) got = 1;
    end
    chk("f2_fetch_granted", got, 1);
    chk("f2_fetch_address", mem_address, 32'h200);
    tick();
    chk("f2_fetch_data", fetch_data, 32'hA000_0080);
    fetch_request = 0;
    tick();

    // data request with no flag: error completion, no memory access
    data_address = 32'h44; data_request = 1;
    tick();
    chk("err_ready", data_ready, 1);
    chk("err_read_data", data_read_data, 0);
    chk("err_no_access", {mem_read, mem_write}, 0);
    data_request = 0;
    tick();
    chk("err_ready_pulse", data_ready, 0);

    // continuous data stream with fetch pending
    fetch_address = 32'h300; fetch_request = 1;
    data_address = 32'h40; data_read = 1; data_request = 1;
    fdone = 0; fgrant = 0; prev_rd = 0; dgrants = 0; dgrants_before = -1;
    for (int i = 0; i < 60 && !fdone; i++) begin
      tick();
      if (mem_read && !prev_rd) begin
        if (mem_address == 32'h300) begin
          if (!fgrant) dgrants_before = dgrants;
          fgrant = 1;
        end else begin
          dgrants++;
        end
      end
      prev_rd = mem_read;
      if (fetch_ready) fdone = 1;
    end
    chk("burst_fetch_granted", fgrant, 1);
    chk("burst_data_grants", 64'(dgrants_before), 64'(4));
    chk("burst_fetch_data", fetch_data, 32'hA000_00C0);
    fetch_request = 0; data_request = 0; data_read = 0;
    tick(); tick();

    // cx mismatch: compare 6 against 5
    data_address = 32'h20; data_read = 1; data_write = 1;
    data_compare = 32'd6; data_write_data = 32'd9; data_request = 1;
    tick();
    chk("cxm_read", mem_read, 1);
    chk("cxm_address", mem_address, 32'h20);
    tick();
    chk("cxm_ready", data_ready, 1);
    chk("cxm_success", cx_success, 0);
    chk("cxm_old", data_read_data, 5);
    chk("cxm_no_write", mem_write, 0);
    data_request = 0;
    tick();
    chk("cxm_still_no_write", mem_write, 0);
    chk("cxm_mem", mem[8], 5);

    // cx match: compare 5, new 9
    data_compare = 32'd5; data_request = 1;
    tick();
    chk("cx_read", mem_read, 1);
    tick();
    chk("cx_write", mem_write, 1);
    chk("cx_write_data", mem_write_data, 9);
    chk("cx_read_dropped", mem_read, 0);
    chk("cx_not_done", data_ready, 0);
    tick();
    chk("cx_ready", data_ready, 1);
    chk("cx_success", cx_success, 1);
    chk("cx_old", data_read_data, 5);
    data_request = 0;
    tick();
    chk("cx_success_pulse", cx_success, 0);
    chk("cx_mem", mem[8], 9);

    // cx with 3 wait states and fetch pending: fetch locked out
    wait_states = 3;
    fetch_address = 32'h100; fetch_request = 1;
    data_compare = 32'd9; data_write_data = 32'd7; data_request = 1;
    leak = 0; wseen = 0; dr = 0; cx_s = 0; rdd = 0;
    for (int i = 0; i < 40 && !dr; i++) begin
      tick();
      if (mem_read && mem_address == 32'h100) leak = 1;
      if (mem_write && mem_address == 32'h20) wseen = 1;
      if (data_ready) begin dr = 1; cx_s = cx_success; rdd = data_read_data; end
    end
    data_request = 0; data_read = 0; data_write = 0;
    chk("cxw_done", dr, 1);
    chk("cxw_no_fetch_between", leak, 0);
    chk("cxw_wrote", wseen, 1);
    chk("cxw_success", cx_s, 1);
    chk("cxw_old", rdd, 9);
    chk("cxw_mem", mem[8], 7);
    fr = 0; fd = 0;
    for (int i = 0; i < 40 && !fr; i++) begin
      tick();
      if (fetch_ready) begin fr = 1; fd = fetch_data; end
    end
    fetch_request = 0;
    chk("cxw_fetch_after", fd, 32'hA000_0040);
    tick();

    // fetch cancelled mid-access with 2 wait states
    wait_states = 2;
    fetch_address = 32'h100; fetch_request = 1;
    tick();
    chk("cn_grant", mem_read, 1);
    rdcyc = 1;
    fetch_cancel = 1; fetch_request = 0;
    tick();
    fetch_cancel = 0;
    fseen = 0;
    for (int i = 0; i < 10; i++) begin
      if (fetch_ready) fseen = 1;
      if (mem_read) rdcyc++;
      tick();
    end
    chk("cn_rd_cycles", 64'(rdcyc), 64'(3));
    chk("cn_no_ready", fseen, 0);
    fetch_address = 32'h200; fetch_request = 1;
    fr = 0; fd = 0;
    for (int i = 0; i < 40 && !fr; i++) begin
      tick();
      if (fetch_ready) begin fr = 1; fd = fetch_data; end
    end
    fetch_request = 0;
    chk("cn_next_fetch", fd, 32'hA000_0080);
    tick();

    // reset during DATA_WRITE wait
    wait_states = 3;
    data_address = 32'h40; data_write = 1; data_read = 0;
    data_write_data = 32'h55; data_request = 1;
    tick();
    chk("rw_write", mem_write, 1);
    chk("rw_write_data", mem_write_data, 32'h55);
    tick();
    reset = 1;
    #1;
    chk("rw_rst_write", mem_write, 0);
    chk("rw_rst_address", mem_address, 0);
    chk("rw_rst_wdata", mem_write_data, 0);
    chk("rw_rst_read_data", data_read_data, 0);
    chk("rw_rst_fetch_data", fetch_data, 0);
    chk("rw_rst_ready", {fetch_ready, data_ready, cx_success}, 0);
    data_request = 0; data_write = 0;
    tick(); tick();
    reset = 0;
    drs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_ready) drs = 1;
    end
    chk("rw_no_stale_ready", drs, 0);
    wait_states = 0;
    data_read = 1; data_request = 1;
    tick();
    chk("rw_new_read", mem_read, 1);
    tick();
    chk("rw_new_ready", data_ready, 1);
    chk("rw_new_value", data_read_data, 32'hA000_0010);
    data_request = 0; data_read = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
